// File: rtl/shift_register_pkg.sv
// Shared types for the serial-in, parallel-out capture register.
// Holds the default chain width and the per-edge operation decode.
package shift_register_pkg;

  localparam int unsigned DEFAULT_WIDTH = 512;

  typedef enum logic [1:0] {
    OP_SHIFT = 2'd0,
    OP_LOAD  = 2'd1,
    OP_RESET = 2'd2
  } op_e;

  // Reset outranks load, and load outranks shift.
  function automatic op_e decode_op(input logic reset, input logic load);
    if (reset) begin
      return OP_RESET;
    end else if (load) begin
      return OP_LOAD;
    end else begin
      return OP_SHIFT;
    end
  endfunction

endpackage

// File: rtl/shift_register_if.sv
// Bundle of serial input, load strobe and parallel snapshot for the capture register.
// The master drives the stream and the strobe; the slave owns the snapshot.
interface shift_register_if
  import shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             shift_in;
  logic             load;
  logic [WIDTH-1:0] data_out;

  modport master (
    output shift_in,
    output load,
    input  data_out
  );

  modport slave (
    input  shift_in,
    input  load,
    output data_out
  );

endinterface

// File: rtl/shift_register.sv
// Serial-in, parallel-out capture register for the fast readout path.
// Bits enter at bit 0 each clock; load copies the chain to data_out and clears the chain.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  shift_register_if.slave  bus
);

  logic [WIDTH-1:0] sr;
  op_e              op;

  always_comb begin
    op = decode_op(reset, bus.load);
  end

  // Shift chain; the oldest bit falls off the MSB end without any flag.
  always_ff @(posedge clk) begin
    case (op)
      OP_RESET: sr <= '0;
      OP_LOAD:  sr <= '0;
      default:  sr <= {sr[WIDTH-2:0], bus.shift_in};
    endcase
  end

  // Snapshot takes the pre-edge chain, so the bit shifted in on the load edge is lost.
  always_ff @(posedge clk) begin
    case (op)
      OP_RESET: bus.data_out <= '0;
      OP_LOAD:  bus.data_out <= sr;
      default:  bus.data_out <= bus.data_out;
    endcase
  end

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register: stimulus pushes the expected snapshot per load,
// a monitor pops and compares on the half cycle after every sampled load.
module tb_shift_register;

  localparam int unsigned W = 512;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [W-1:0] exp_q[$];

  shift_register_if #(.WIDTH(W)) ifc ();

  shift_register #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Monitor: any load sampled without reset produces a snapshot to compare.
  initial begin
    logic [W-1:0] exp_v;
    forever begin
      @(posedge clk);
      if (ifc.load === 1'b1 && reset === 1'b0) begin
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_load: got data_out=%h with no expected entry", ifc.data_out[63:0]);
        end else begin
          exp_v = exp_q.pop_front();
          if (ifc.data_out !== exp_v) begin
            failures++;
            $display("FAIL load_snapshot: got low=%h high=%h, expected low=%h high=%h",
                     ifc.data_out[63:0], ifc.data_out[W-1:W-64], exp_v[63:0], exp_v[W-1:W-64]);
          end
        end
      end
    end
  end

  // Called at a negedge: set inputs, then advance to the next negedge.
  task automatic step(input logic r, input logic l, input logic s);
    reset        = r;
    ifc.load     = l;
    ifc.shift_in = s;
    @(negedge clk);
  endtask

  task automatic shift_bit(input logic s);
    step(1'b0, 1'b0, s);
  endtask

  task automatic load_expect(input logic [W-1:0] e, input logic s);
    exp_q.push_back(e);
    step(1'b0, 1'b1, s);
  endtask

  task automatic check_now(input string name, input logic [W-1:0] e);
    checks++;
    if (ifc.data_out !== e) begin
      failures++;
      $display("FAIL %s: got low=%h, expected low=%h", name, ifc.data_out[63:0], e[63:0]);
    end
  endtask

  initial begin
    logic [W-1:0] e;
    logic [7:0]   pat;
    int           idx[$];
    int           wait_cycles;

    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    ifc.load     = 1'b0;
    ifc.shift_in = 1'b1;
    @(negedge clk);

    // 1: reset held 10 cycles with ones on the input, then released
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1);
    check_now("reset_state", '0);
    load_expect('0, 1'b0);

    // 2: walking one at a selection of positions including both ends
    for (int i = 0; i < 32; i++) idx.push_back(i);
    idx.push_back(255);
    idx.push_back(256);
    for (int i = 500; i < 512; i++) idx.push_back(i);
    foreach (idx[n]) begin
      shift_bit(1'b1);
      for (int k = 0; k < idx[n]; k++) shift_bit(1'b0);
      e = '0;
      e[idx[n]] = 1'b1;
      load_expect(e, 1'b0);
    end

    // 3: 0xA5 MSB first, then data_out must hold while shifting continues
    pat = 8'hA5;
    for (int k = 7; k >= 0; k--) shift_bit(pat[k]);
    e = '0;
    e[7:0] = 8'hA5;
    load_expect(e, 1'b0);
    for (int k = 0; k < 6; k++) shift_bit(1'b1);
    check_now("hold_between_loads", e);
    load_expect({{(W-6){1'b0}}, 6'b111111}, 1'b0);

    // 4: overflow with WIDTH+3 ones, then back-to-back load captures zeros
    for (int k = 0; k < W + 3; k++) shift_bit(1'b1);
    load_expect('1, 1'b0);
    load_expect('0, 1'b0);

    // 5: reset mid-stream drops partial data
    for (int k = 0; k < 5; k++) shift_bit(1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_now("reset_midstream", '0);
    shift_bit(1'b1);
    shift_bit(1'b0);
    load_expect({{(W-2){1'b0}}, 2'b10}, 1'b0);

    // 5b: reset wins over a simultaneous load
    for (int k = 0; k < 4; k++) shift_bit(1'b1);
    step(1'b1, 1'b1, 1'b1);
    check_now("reset_over_load", '0);
    load_expect('0, 1'b0);

    // 6: shift_in ignored on the load edge, chain cleared afterwards
    for (int k = 0; k < 3; k++) shift_bit(1'b1);
    load_expect({{(W-3){1'b0}}, 3'b111}, 1'b1);
    load_expect('0, 1'b0);

    step(1'b0, 1'b0, 1'b0);
    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected snapshots never observed", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
